// File: rtl/nla_pkg.sv
// Shared definitions for the MAC stream feeder.
//   - Default word width and buffer address width.
//   - Terminator word (signalling NaN) emitted after each stream when the
//     terminator build option is enabled.
//   - FSM state encoding used by mac_stream_feeder.
package nla_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_LINES = 5;

    localparam logic [31:0] NAN_TERM = 32'h7F90_0000;

    typedef enum logic [2:0] {
        IDLE,
        SEND_SIG,
        SIG_TERM,
        SEND_COEFF,
        COEFF_TERM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/feeder_buf.sv
// One per-stream word buffer of 2**ADDR_LINES entries.
// Ports:
//   clk_i                  clock
//   wr_en_i / wr_addr_i / wr_data_i   single write port
//   rd_idx_i               read index (driven from a register in the parent)
//   rd_data_o              word at rd_idx_i
// Contents are not reset; the parent's counters gate what is reachable.
module feeder_buf
    import nla_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_LINES = DEF_ADDR_LINES
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_LINES-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_LINES-1:0] rd_idx_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_LINES];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/mac_stream_feeder.sv
// Buffers host-written signal samples and coefficients, then on start_i
// streams all signal words followed by all coefficient words to a MAC,
// one word per cycle, honouring per-phase back-pressure.
// Ports:
//   clk_i, rst_i                       clock, async active-high reset
//   sig_wr_en_i / sig_wr_data_i        host signal write
//   coeff_wr_en_i / coeff_wr_data_i    host coefficient write
//   start_i                            launch streaming (pulse)
//   full_mul_i / full_adder_i          stall signal / coefficient phase
//   signal_fifo_o / signal_valid_o     signal word stream
//   coeff_fifo_o / coeff_valid_o       coefficient word stream
//   busy_o / done_o / ovf_o            active, completion pulse, sticky overflow
// Build option: MAC_FEEDER_NAN_TERM_EN -- emit a signalling-NaN terminator
// word after each stream; otherwise the terminator states emit nothing.
module mac_stream_feeder
    import nla_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_LINES = DEF_ADDR_LINES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sig_wr_en_i,
    input  logic [DATA_WIDTH-1:0] sig_wr_data_i,
    input  logic                  coeff_wr_en_i,
    input  logic [DATA_WIDTH-1:0] coeff_wr_data_i,
    input  logic                  start_i,
    input  logic                  full_mul_i,
    input  logic                  full_adder_i,
    output logic [DATA_WIDTH-1:0] signal_fifo_o,
    output logic                  signal_valid_o,
    output logic [DATA_WIDTH-1:0] coeff_fifo_o,
    output logic                  coeff_valid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  ovf_o
);

    localparam logic [ADDR_LINES:0] FULL_CNT = (ADDR_LINES+1)'(2**ADDR_LINES);

    feeder_state_t         state_q, state_d;
    logic [ADDR_LINES:0]   sig_cnt_q, sig_cnt_d;
    logic [ADDR_LINES:0]   coeff_cnt_q, coeff_cnt_d;
    logic [ADDR_LINES:0]   rd_idx_q, rd_idx_d;
    logic [DATA_WIDTH-1:0] sig_word_q, sig_word_d;
    logic [DATA_WIDTH-1:0] coeff_word_q, coeff_word_d;
    logic                  sig_valid_q, sig_valid_d;
    logic                  coeff_valid_q, coeff_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  sig_we, coeff_we, host_ok;
    logic [ADDR_LINES:0]   rd_nxt;
    logic [DATA_WIDTH-1:0] sig_rd_data, coeff_rd_data;

    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_LINES(ADDR_LINES)) u_sig_buf (
        .clk_i     (clk_i),
        .wr_en_i   (sig_we),
        .wr_addr_i (sig_cnt_q[ADDR_LINES-1:0]),
        .wr_data_i (sig_wr_data_i),
        .rd_idx_i  (rd_idx_q[ADDR_LINES-1:0]),
        .rd_data_o (sig_rd_data)
    );

    feeder_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_LINES(ADDR_LINES)) u_coeff_buf (
        .clk_i     (clk_i),
        .wr_en_i   (coeff_we),
        .wr_addr_i (coeff_cnt_q[ADDR_LINES-1:0]),
        .wr_data_i (coeff_wr_data_i),
        .rd_idx_i  (rd_idx_q[ADDR_LINES-1:0]),
        .rd_data_o (coeff_rd_data)
    );

    always_comb begin
        state_d       = state_q;
        sig_cnt_d     = sig_cnt_q;
        coeff_cnt_d   = coeff_cnt_q;
        rd_idx_d      = rd_idx_q;
        sig_word_d    = sig_word_q;
        coeff_word_d  = coeff_word_q;
        sig_valid_d   = 1'b0;
        coeff_valid_d = 1'b0;
        done_d        = 1'b0;
        ovf_d         = ovf_q;
        sig_we        = 1'b0;
        coeff_we      = 1'b0;
        rd_nxt        = rd_idx_q + 1'b1;
        // busy_q is still high for the cycle after DONE, so gate on it too.
        host_ok       = (state_q == IDLE) && !busy_q;

        if (host_ok) begin
            if (sig_wr_en_i) begin
                if (sig_cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    sig_we    = 1'b1;
                    sig_cnt_d = sig_cnt_q + 1'b1;
                end
            end
            if (coeff_wr_en_i) begin
                if (coeff_cnt_q == FULL_CNT) begin
                    ovf_d = 1'b1;
                end else begin
                    coeff_we    = 1'b1;
                    coeff_cnt_d = coeff_cnt_q + 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (host_ok && start_i) begin
                    rd_idx_d = '0;
                    // Uses the post-write count so a same-cycle write is streamed.
                    state_d  = (sig_cnt_d == '0) ? SIG_TERM : SEND_SIG;
                end
            end
            SEND_SIG: begin
                if (!full_mul_i) begin
                    sig_word_d  = sig_rd_data;
                    sig_valid_d = 1'b1;
                    if (rd_nxt == sig_cnt_q) begin
                        rd_idx_d = '0;
                        state_d  = SIG_TERM;
                    end else begin
                        rd_idx_d = rd_nxt;
                    end
                end
            end
            SIG_TERM: begin
`ifdef MAC_FEEDER_NAN_TERM_EN
                if (!full_mul_i) begin
                    sig_word_d  = DATA_WIDTH'(NAN_TERM);
                    sig_valid_d = 1'b1;
                    state_d     = (coeff_cnt_q == '0) ? COEFF_TERM : SEND_COEFF;
                end
`else
                state_d = (coeff_cnt_q == '0) ? COEFF_TERM : SEND_COEFF;
`endif
            end
            SEND_COEFF: begin
                if (!full_adder_i) begin
                    coeff_word_d  = coeff_rd_data;
                    coeff_valid_d = 1'b1;
                    if (rd_nxt == coeff_cnt_q) begin
                        rd_idx_d = '0;
                        state_d  = COEFF_TERM;
                    end else begin
                        rd_idx_d = rd_nxt;
                    end
                end
            end
            COEFF_TERM: begin
`ifdef MAC_FEEDER_NAN_TERM_EN
                if (!full_adder_i) begin
                    coeff_word_d  = DATA_WIDTH'(NAN_TERM);
                    coeff_valid_d = 1'b1;
                    state_d       = DONE;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                done_d      = 1'b1;
                sig_cnt_d   = '0;
                coeff_cnt_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered busy stays high through the cycle done_o is shown.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            sig_cnt_q     <= '0;
            coeff_cnt_q   <= '0;
            rd_idx_q      <= '0;
            sig_word_q    <= '0;
            coeff_word_q  <= '0;
            sig_valid_q   <= 1'b0;
            coeff_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sig_cnt_q     <= sig_cnt_d;
            coeff_cnt_q   <= coeff_cnt_d;
            rd_idx_q      <= rd_idx_d;
            sig_word_q    <= sig_word_d;
            coeff_word_q  <= coeff_word_d;
            sig_valid_q   <= sig_valid_d;
            coeff_valid_q <= coeff_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
        end
    end

    assign signal_fifo_o  = sig_word_q;
    assign signal_valid_o = sig_valid_q;
    assign coeff_fifo_o   = coeff_word_q;
    assign coeff_valid_o  = coeff_valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_mac_stream_feeder.sv
// Scoreboard bench for mac_stream_feeder: the stimulus side keeps a queue
// model of the loaded words and pushes the expected stream on start; a
// separate monitor pops and compares every valid word, and checks stall,
// hold and done behaviour.
module tb_mac_stream_feeder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        sig_wr_en_i = 1'b0, coeff_wr_en_i = 1'b0;
    logic [31:0] sig_wr_data_i = '0, coeff_wr_data_i = '0;
    logic        start_i = 1'b0, full_mul_i = 1'b0, full_adder_i = 1'b0;
    logic [31:0] signal_fifo_o, coeff_fifo_o;
    logic        signal_valid_o, coeff_valid_o, busy_o, done_o, ovf_o;

    always #5 clk = ~clk;

    mac_stream_feeder dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .sig_wr_en_i     (sig_wr_en_i),
        .sig_wr_data_i   (sig_wr_data_i),
        .coeff_wr_en_i   (coeff_wr_en_i),
        .coeff_wr_data_i (coeff_wr_data_i),
        .start_i         (start_i),
        .full_mul_i      (full_mul_i),
        .full_adder_i    (full_adder_i),
        .signal_fifo_o   (signal_fifo_o),
        .signal_valid_o  (signal_valid_o),
        .coeff_fifo_o    (coeff_fifo_o),
        .coeff_valid_o   (coeff_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .ovf_o           (ovf_o)
    );

    localparam logic [31:0] NAN_W = 32'h7F90_0000;

    typedef struct packed {
        logic        coeff;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_sig[$], m_coeff[$];
    bit          m_ovf = 0, m_busy = 0;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, done_cyc = -1, sig_seen = 0, coeff_seen = 0;
    int first_cyc = -1, start_cyc = 0;
    logic [31:0] last_sig = '0, last_coeff = '0;
    logic        prev_mul = 1'b0, prev_add = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    task automatic pop_cmp(input logic is_coeff, input logic [31:0] data, output logic [31:0] ref_data);
        exp_t e;
        ref_data = data;
        if (exp_q.size() == 0) begin
            chk(is_coeff ? "unexpected_coeff_word" : "unexpected_sig_word", data, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            chk("word_kind", 32'(is_coeff), 32'(e.coeff));
            chk("word_data", data, e.data);
            ref_data = e.data;
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    // Monitor: all output checks happen on the falling edge.
    initial forever begin
        logic [31:0] r;
        @(negedge clk);
        if (rst_i) begin
            last_sig   = '0;
            last_coeff = '0;
        end else begin
            if (signal_valid_o && coeff_valid_o) chk("both_valid", 1, 0);
            if (signal_valid_o) begin
                chk("sig_valid_while_stalled", 32'(prev_mul), 0);
                if (first_cyc < 0) first_cyc = cyc;
                pop_cmp(1'b0, signal_fifo_o, r);
                last_sig = r;
                sig_seen++;
            end else begin
                chk("sig_hold", signal_fifo_o, last_sig);
            end
            if (coeff_valid_o) begin
                chk("coeff_valid_while_stalled", 32'(prev_add), 0);
                if (first_cyc < 0) first_cyc = cyc;
                pop_cmp(1'b1, coeff_fifo_o, r);
                last_coeff = r;
                coeff_seen++;
            end else begin
                chk("coeff_hold", coeff_fifo_o, last_coeff);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_pending_words", exp_q.size(), 0);
            end
        end
        prev_mul = full_mul_i;
        prev_add = full_adder_i;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return 32'h7FC0_0001;
            1:       return 32'hFF80_0000;
            2:       return 32'h7F80_0001;
            default: return $urandom();
        endcase
    endfunction

    task automatic hw(input bit se, input logic [31:0] sd, input bit ce, input logic [31:0] cd);
        sig_wr_en_i = se; sig_wr_data_i = sd;
        coeff_wr_en_i = ce; coeff_wr_data_i = cd;
        if (!m_busy) begin
            if (se) begin
                if (m_sig.size() == 32) m_ovf = 1; else m_sig.push_back(sd);
            end
            if (ce) begin
                if (m_coeff.size() == 32) m_ovf = 1; else m_coeff.push_back(cd);
            end
        end
        step();
        sig_wr_en_i = 0; coeff_wr_en_i = 0;
    endtask

    task automatic start_run();
        foreach (m_sig[i]) exp_q.push_back('{coeff: 1'b0, data: m_sig[i]});
`ifdef MAC_FEEDER_NAN_TERM_EN
        exp_q.push_back('{coeff: 1'b0, data: NAN_W});
`endif
        foreach (m_coeff[i]) exp_q.push_back('{coeff: 1'b1, data: m_coeff[i]});
`ifdef MAC_FEEDER_NAN_TERM_EN
        exp_q.push_back('{coeff: 1'b1, data: NAN_W});
`endif
        chk("busy_before_start", 32'(busy_o), 0);
        first_cyc = -1;
        start_cyc = cyc;
        start_i = 1;
        step();
        start_i = 0;
        m_busy = 1;
        chk("busy_after_start", 32'(busy_o), 1);
    endtask

    // mode 0: no back-pressure, mode 1: random back-pressure on both phases.
    task automatic wait_done(input int mode);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < 3000) begin
            if (mode == 1) begin
                full_mul_i   = ($urandom_range(0, 9) < 3);
                full_adder_i = ($urandom_range(0, 9) < 3);
            end
            step();
            n++;
        end
        full_mul_i = 0; full_adder_i = 0;
        chk("done_pulses", done_cnt - base, 1);
        chk("words_left", exp_q.size(), 0);
        exp_q.delete();
        m_sig.delete(); m_coeff.delete();
        m_busy = 0;
        chk("ovf_sticky", 32'(ovf_o), 32'(m_ovf));
    endtask

    initial begin
        int b, n, ns, nc;
        // Reset state
        #2;
        chk("rst_sig_fifo", signal_fifo_o, 0);
        chk("rst_coeff_fifo", coeff_fifo_o, 0);
        chk("rst_valids", {30'd0, signal_valid_o, coeff_valid_o}, 0);
        chk("rst_flags", {29'd0, busy_o, done_o, ovf_o}, 0);
        step(); step();
        rst_i = 0;
        step();

        // Directed stream with back-to-back words and registered latency.
        hw(1, 32'hC0A0_0000, 1, 32'h3F00_0000);
        hw(1, 32'hC080_0000, 1, 32'h3F80_0000);
        hw(1, 32'h3F80_0000, 0, 32'h0);
        b = sig_seen;
        start_run();
        wait_done(0);
        chk("first_word_latency", first_cyc - start_cyc, 2);
        chk("sig_words_directed", sig_seen - b,
`ifdef MAC_FEEDER_NAN_TERM_EN
            4
`else
            3
`endif
        );

        // Four-cycle full_mul_i stall in the middle of the signal phase.
        for (int i = 0; i < 5; i++) hw(1, 32'h4000_0000 + i, i < 2, 32'h4100_0000 + i);
        b = sig_seen;
        start_run();
        n = 0;
        while (sig_seen == b && n < 100) begin step(); n++; end
        full_mul_i = 1;
        repeat (4) step();
        full_mul_i = 0;
        wait_done(0);

        // Writes and start while busy are ignored.
        hw(1, 32'h1111_1111, 1, 32'h2222_2222);
        hw(1, 32'h3333_3333, 1, 32'h4444_4444);
        start_run();
        for (int i = 0; i < 4; i++) begin
            chk("busy_during_stream", 32'(busy_o), 1);
            start_i = (i == 1);
            hw(1, $urandom(), 1, $urandom());
        end
        start_i = 0;
        wait_done(0);

        // Empty start: done four cycles after start, no words expected.
        start_run();
        wait_done(0);
        chk("empty_done_latency", done_cyc - start_cyc, 4);

        // Overflow: 33 signal writes, 32 streamed.
        chk("ovf_before", 32'(ovf_o), 0);
        for (int i = 0; i < 33; i++) hw(1, rnd_word(), i == 0, rnd_word());
        chk("ovf_after_33", 32'(ovf_o), 1);
        chk("busy_idle", 32'(busy_o), 0);
        b = sig_seen;
        start_run();
        wait_done(0);
        chk("sig_words_full",
            sig_seen - b,
`ifdef MAC_FEEDER_NAN_TERM_EN
            33
`else
            32
`endif
        );

        // Randomised loads with random back-pressure.
        for (int t = 0; t < 6; t++) begin
            ns = $urandom_range(0, 32);
            nc = $urandom_range(0, 32);
            for (int i = 0; i < ((ns > nc) ? ns : nc); i++)
                hw(i < ns, rnd_word(), i < nc, rnd_word());
            start_run();
            wait_done(1);
        end

        // Reset after the second coefficient word.
        hw(1, 32'hAAAA_0001, 1, 32'hBBBB_0001);
        hw(1, 32'hAAAA_0002, 1, 32'hBBBB_0002);
        hw(1, 32'hAAAA_0003, 1, 32'hBBBB_0003);
        hw(0, 32'h0, 1, 32'hBBBB_0004);
        b = coeff_seen;
        start_run();
        n = 0;
        while (coeff_seen - b < 2 && n < 200) begin @(negedge clk); #2; n++; end
        chk("reached_second_coeff", coeff_seen - b, 2);
        rst_i = 1;
        #1;
        chk("midrst_sig_fifo", signal_fifo_o, 0);
        chk("midrst_coeff_fifo", coeff_fifo_o, 0);
        chk("midrst_valids", {30'd0, signal_valid_o, coeff_valid_o}, 0);
        chk("midrst_flags", {29'd0, busy_o, done_o, ovf_o}, 0);
        exp_q.delete(); m_sig.delete(); m_coeff.delete();
        m_ovf = 0; m_busy = 0;
        step(); step();
        rst_i = 0;
        repeat (5) step();
        hw(1, 32'h7F80_0000, 1, 32'hFFC0_0000);
        hw(1, 32'h0000_0001, 0, 32'h0);
        start_run();
        wait_done(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
